// File: rtl/aqed_rb_monitor.sv
// Response-bound monitor for the A-QED harness: timestamps accepted writes,
// matches DUT outputs in order and flags timeout, spurious and overflow errors.
module aqed_rb_monitor #(
    parameter int DEPTH    = 16,
    parameter int TS_W     = 8,
    parameter int RB_BOUND = 32,
    parameter int CHECK_N  = 8,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_valid,
    output logic             rb_done,
    output logic             rb_check,
    output logic [CNT_W-1:0] outstanding,
    output logic [2:0]       err_code,
    output logic [TS_W-1:0]  max_latency
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DC_W  = $clog2(CHECK_N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FAIL = 2'd2;

    logic [TS_W-1:0]  ts_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [TS_W-1:0]  cyc;
    logic [DC_W-1:0]  done_cnt;
    logic [1:0]       state;
    logic [1:0]       state_next;

    logic             fifo_empty;
    logic             fifo_full;
    logic [TS_W-1:0]  head_age;
    logic             do_pop;
    logic             do_push;
    logic             spurious;
    logic             overflow;
    logic             timeout;
    logic [2:0]       err_next;
    logic [CNT_W-1:0] count_next;

    // Pop is judged on pre-push contents, so a full FIFO that pops this
    // cycle still has room for a same-cycle push.
    always_comb begin
        fifo_empty = (outstanding == '0);
        fifo_full  = (outstanding == CNT_W'(DEPTH));
        head_age   = cyc - ts_mem[rd_ptr];
        do_pop     = out_valid & ~flush & ~fifo_empty;
        spurious   = out_valid & ~flush & fifo_empty;
        do_push    = in_valid & ~flush & (~fifo_full | do_pop);
        overflow   = in_valid & ~flush & fifo_full & ~do_pop;
        timeout    = ~fifo_empty & (head_age > TS_W'(RB_BOUND));
        err_next   = err_code | {timeout, spurious, overflow};

        count_next = outstanding;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = outstanding + CNT_W'(1);
        else if (do_pop && !do_push)
            count_next = outstanding - CNT_W'(1);

        state_next = state;
        if (state == S_FAIL || err_next != 3'b000)
            state_next = S_FAIL;
        else if (count_next != '0)
            state_next = S_BUSY;
        else
            state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (clk_en && do_push)
            ts_mem[wr_ptr] <= cyc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cyc         <= '0;
            done_cnt    <= '0;
            state       <= S_IDLE;
            outstanding <= '0;
            err_code    <= 3'b000;
            max_latency <= '0;
            rb_done     <= 1'b0;
            rb_check    <= 1'b1;
        end else if (clk_en) begin
            state       <= state_next;
            outstanding <= count_next;
            err_code    <= err_next;
            rb_check    <= (err_code == 3'b000);
            if (do_pop && head_age > max_latency)
                max_latency <= head_age;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cyc    <= '0;
            end else begin
                cyc <= cyc + TS_W'(1);
                if (do_push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end

            // Done bookkeeping survives a flush only once the check has failed.
            if (flush && state != S_FAIL) begin
                done_cnt <= '0;
                rb_done  <= 1'b0;
            end else begin
                if (do_pop && done_cnt != DC_W'(CHECK_N))
                    done_cnt <= done_cnt + DC_W'(1);
                rb_done <= rb_done | (done_cnt == DC_W'(CHECK_N)) | (state == S_FAIL);
            end
        end
    end

endmodule

// File: tb/tb_aqed_rb_monitor.sv
// Directed bench for aqed_rb_monitor with RB_BOUND=4, CHECK_N=3, DEPTH=4.
module tb_aqed_rb_monitor;

    localparam int DEPTH    = 4;
    localparam int TS_W     = 8;
    localparam int RB_BOUND = 4;
    localparam int CHECK_N  = 3;
    localparam int CNT_W    = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FAIL = 2'd2;

    logic             clk;
    logic             reset;
    logic             clk_en;
    logic             flush;
    logic             in_valid;
    logic             out_valid;
    logic             rb_done;
    logic             rb_check;
    logic [CNT_W-1:0] outstanding;
    logic [2:0]       err_code;
    logic [TS_W-1:0]  max_latency;

    int checks = 0;
    int errors = 0;

    aqed_rb_monitor #(
        .DEPTH(DEPTH), .TS_W(TS_W), .RB_BOUND(RB_BOUND),
        .CHECK_N(CHECK_N), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .flush(flush),
        .in_valid(in_valid), .out_valid(out_valid),
        .rb_done(rb_done), .rb_check(rb_check), .outstanding(outstanding),
        .err_code(err_code), .max_latency(max_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, settle 1 ns past it.
    task automatic cycle(input logic iv, input logic ov, input logic fl = 1'b0,
                         input logic en = 1'b1);
        in_valid  = iv;
        out_valid = ov;
        flush     = fl;
        clk_en    = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_valid = 1'b0; flush = 1'b0; clk_en = 1'b1;
        @(posedge clk); @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_done"},   32'(rb_done), 32'd0);
        chk({tag, "_check"},  32'(rb_check), 32'd1);
        chk({tag, "_outst"},  32'(outstanding), 32'd0);
        chk({tag, "_err"},    32'(err_code), 32'd0);
        chk({tag, "_maxlat"}, 32'(max_latency), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_reset_vals("rst");

        // Three writes then three in-order outputs, latency 3 each
        cycle(1, 0); chk("t1_out_c0", 32'(outstanding), 32'd1);
        cycle(1, 0); chk("t1_out_c1", 32'(outstanding), 32'd2);
        cycle(1, 0); chk("t1_out_c2", 32'(outstanding), 32'd3);
        cycle(0, 1); chk("t1_out_c3", 32'(outstanding), 32'd2);
        cycle(0, 1); chk("t1_out_c4", 32'(outstanding), 32'd1);
        cycle(0, 1); chk("t1_out_c5", 32'(outstanding), 32'd0);
        chk("t1_maxlat", 32'(max_latency), 32'd3);
        chk("t1_state",  32'(dut.state), 32'(S_IDLE));
        cycle(0, 0);
        chk("t1_done",  32'(rb_done), 32'd1);
        chk("t1_check", 32'(rb_check), 32'd1);
        chk("t1_err",   32'(err_code), 32'd0);

        // Timeout: single write, never answered
        do_reset();
        cycle(1, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 0);
        chk("to_err_c4", 32'(err_code), 32'd0);
        cycle(0, 0);
        chk("to_err_c5",   32'(err_code), 32'b100);
        chk("to_state_c5", 32'(dut.state), 32'(S_FAIL));
        cycle(0, 0);
        chk("to_done",  32'(rb_done), 32'd1);
        chk("to_check", 32'(rb_check), 32'd0);
        // Flush while failed keeps the failure
        cycle(0, 0, 1);
        chk("fl_fail_err",   32'(err_code), 32'b100);
        chk("fl_fail_state", 32'(dut.state), 32'(S_FAIL));
        chk("fl_fail_done",  32'(rb_done), 32'd1);
        chk("fl_fail_outst", 32'(outstanding), 32'd0);

        // Spurious output with nothing outstanding
        do_reset();
        cycle(0, 0); cycle(0, 0); cycle(0, 1);
        chk("sp_err",   32'(err_code), 32'b010);
        chk("sp_outst", 32'(outstanding), 32'd0);
        cycle(0, 0);
        chk("sp_check", 32'(rb_check), 32'd0);

        // Same-cycle write and output while empty
        do_reset();
        cycle(1, 1);
        chk("sp2_err",   32'(err_code), 32'b010);
        chk("sp2_outst", 32'(outstanding), 32'd1);

        // Overflow at DEPTH=4
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 0);
        chk("ov_outst4", 32'(outstanding), 32'd4);
        chk("ov_err4",   32'(err_code), 32'd0);
        cycle(1, 0);
        chk("ov_err5",   32'(err_code), 32'b001);
        chk("ov_outst5", 32'(outstanding), 32'd4);

        // Flush with two outstanding, then idle to cycle 20
        do_reset();
        cycle(1, 0); cycle(1, 0);
        cycle(0, 0);
        chk("fl_outst_c2", 32'(outstanding), 32'd2);
        cycle(0, 0, 1);
        chk("fl_outst_c3", 32'(outstanding), 32'd0);
        for (int i = 4; i <= 20; i++) cycle(0, 0);
        chk("fl_outst", 32'(outstanding), 32'd0);
        chk("fl_err",   32'(err_code), 32'd0);
        chk("fl_check", 32'(rb_check), 32'd1);
        chk("fl_state", 32'(dut.state), 32'(S_IDLE));

        // clk_en low freezes ages: latency stays 2 across a 10-cycle stall
        do_reset();
        cycle(1, 0); cycle(0, 0);
        for (int i = 0; i < 10; i++) cycle(1'(i & 1), 1'(~i & 1), 1'b0, 1'b0);
        chk("en_outst_hold", 32'(outstanding), 32'd1);
        chk("en_err_hold",   32'(err_code), 32'd0);
        cycle(0, 1);
        chk("en_maxlat", 32'(max_latency), 32'd2);
        chk("en_outst",  32'(outstanding), 32'd0);
        chk("en_err",    32'(err_code), 32'd0);
        cycle(0, 0, 1);
        chk("en_flush_maxlat", 32'(max_latency), 32'd2);

        // Reset mid-BUSY with clk_en low still clears everything
        cycle(1, 0);
        chk("rb_busy_outst", 32'(outstanding), 32'd1);
        reset = 1'b1; clk_en = 1'b0; in_valid = 1'b0; out_valid = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("rst_mid");
        chk("rst_mid_state", 32'(dut.state), 32'(S_IDLE));
        reset = 1'b0; clk_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
